// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable / divider generator.
// Each channel runs a divisor and mode that are swapped in only at a period boundary.
module clk_div_multi #(
    parameter int NCH = 4,
    parameter int CW = 28,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           Reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_mode,
    input  logic [NCH-1:0] ch_en,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic           cfg_err
);

    localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] set_cfg;
    logic           ch_ok;
    logic           sel_pend;
    logic           xfer;
    logic           legal;

    // Channel numbers at or above NCH have no pending bit; they are always accepted.
    always_comb begin
        ch_ok = 1'b0;
        sel_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_ok = 1'b1;
                sel_pend = pending[i];
            end
        end
    end

    assign cfg_ready = ~sel_pend;
    assign xfer = cfg_valid & cfg_ready;
    assign legal = xfer & ch_ok & (cfg_div != '0);

    always_comb begin
        set_cfg = '0;
        for (int i = 0; i < NCH; i++) begin
            set_cfg[i] = legal & (cfg_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk_in) begin
        if (Reset) begin
            cfg_err <= 1'b0;
        end else if (xfer && (!ch_ok || cfg_div == '0)) begin
            cfg_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] div_act;
        logic [CW-1:0] shadow_div;
        logic          mode;
        logic          shadow_mode;
        logic          pend;
        logic          out_q;
        logic          tick_q;
        logic          last;
        logic          swap;

        assign last = (cnt == div_act - CW'(1));
        // A disabled channel takes its update immediately, a running one waits for the boundary.
        assign swap = pend & (~ch_en[g] | last);

        always_ff @(posedge clk_in) begin
            if (Reset) begin
                cnt <= '0;
                div_act <= DEF_DIV;
                shadow_div <= DEF_DIV;
                mode <= 1'b0;
                shadow_mode <= 1'b0;
                pend <= 1'b0;
                out_q <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (set_cfg[g]) begin
                    shadow_div <= cfg_div;
                    shadow_mode <= cfg_mode;
                end
                if (!ch_en[g]) begin
                    cnt <= '0;
                    out_q <= 1'b0;
                    tick_q <= 1'b0;
                end else if (last) begin
                    cnt <= '0;
                    tick_q <= 1'b1;
                    out_q <= mode ? 1'b1 : ~out_q;
                end else begin
                    cnt <= cnt + CW'(1);
                    tick_q <= 1'b0;
                    if (mode) begin
                        out_q <= 1'b0;
                    end
                end
                if (swap) begin
                    div_act <= shadow_div;
                    mode <= shadow_mode;
                end
                if (set_cfg[g]) begin
                    pend <= 1'b1;
                end else if (swap) begin
                    pend <= 1'b0;
                end
            end
        end

        assign pending[g] = pend;
        assign clk_out[g] = out_q;
        assign tick[g] = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized scoreboard bench for clk_div_multi against a countdown-based reference model.
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int CW = 8;
    localparam int DEF = 5;
    localparam int CHW = 2;

    logic           clk_in = 1'b0;
    logic           Reset = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_mode = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic           cfg_err;

    clk_div_multi #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
        .clk_in(clk_in),
        .Reset(Reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_mode(cfg_mode),
        .ch_en(ch_en),
        .clk_out(clk_out),
        .tick(tick),
        .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
        logic           err;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total = 0;

    // Reference model: each channel counts down the cycles left in its period.
    int m_n[NCH];
    int m_sn[NCH];
    int m_left[NCH];
    bit m_mode[NCH];
    bit m_smode[NCH];
    bit m_pend[NCH];
    bit m_out[NCH];
    bit m_tk[NCH];
    bit m_err;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_n[i] = DEF;
            m_sn[i] = DEF;
            m_left[i] = 0;
            m_mode[i] = 0;
            m_smode[i] = 0;
            m_pend[i] = 0;
            m_out[i] = 0;
            m_tk[i] = 0;
        end
        m_err = 0;
    endfunction

    function automatic bit model_ready(int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            e.co[i] = m_out[i];
            e.tk[i] = m_tk[i];
        end
        e.err = m_err;
        return e;
    endfunction

    function automatic void model_step(bit [NCH-1:0] en, bit v, int ch, int dv, bit md);
        bit acc;
        bit bnd;
        acc = v && model_ready(ch);
        for (int i = 0; i < NCH; i++) begin
            bnd = 0;
            if (!en[i]) begin
                m_left[i] = 0;
                m_out[i] = 0;
                m_tk[i] = 0;
            end else begin
                if (m_left[i] == 0) m_left[i] = m_n[i];
                m_left[i]--;
                bnd = (m_left[i] == 0);
                m_tk[i] = bnd;
                if (bnd) m_out[i] = m_mode[i] ? 1'b1 : !m_out[i];
                else if (m_mode[i]) m_out[i] = 0;
            end
            if ((!en[i] || bnd) && m_pend[i]) begin
                m_n[i] = m_sn[i];
                m_mode[i] = m_smode[i];
                m_pend[i] = 0;
            end
        end
        if (acc) begin
            if (dv == 0 || ch >= NCH) begin
                m_err = 1;
            end else begin
                m_sn[ch] = dv;
                m_smode[ch] = md;
                m_pend[ch] = 1;
            end
        end
    endfunction

    task automatic cyc(bit [NCH-1:0] en, bit v, int ch, int dv, bit md);
        @(negedge clk_in);
        Reset = 1'b0;
        ch_en = en;
        cfg_valid = v;
        cfg_ch = CHW'(ch);
        cfg_div = CW'(dv);
        cfg_mode = md;
        #1;
        chk("cfg_ready", cfg_ready, model_ready(ch));
        model_step(en, v, ch, dv, md);
        q.push_back(model_exp());
    endtask

    task automatic rst();
        @(negedge clk_in);
        Reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = '0;
        cfg_div = '0;
        model_reset();
        q.push_back(model_exp());
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("clk_out", clk_out, e.co);
                chk("tick", tick, e.tk);
                chk("cfg_err", cfg_err, e.err);
            end
        end
    end

    initial begin
        bit [NCH-1:0] en;
        model_reset();
        rst();
        rst();
        repeat (25) cyc(3'b001, 0, 0, 0, 0);
        repeat (7) cyc(3'b011, 0, 0, 0, 0);
        repeat (6) cyc(3'b011, 1, 1, 3, 1);
        repeat (15) cyc(3'b011, 0, 0, 0, 0);
        cyc(3'b011, 1, 2, 0, 0);
        cyc(3'b011, 1, 3, 4, 0);
        repeat (5) cyc(3'b011, 0, 0, 0, 0);
        cyc(3'b111, 1, 0, 1, 0);
        cyc(3'b111, 1, 2, 1, 1);
        repeat (20) cyc(3'b111, 0, 0, 0, 0);
        cyc(3'b111, 1, 1, 6, 0);
        repeat (2) cyc(3'b111, 0, 0, 0, 0);
        rst();
        repeat (10) cyc(3'b111, 0, 0, 0, 0);
        repeat (10) cyc(3'b101, 0, 0, 0, 0);
        repeat (3) cyc(3'b100, 0, 0, 0, 0);
        repeat (12) cyc(3'b101, 0, 0, 0, 0);
        en = 3'b111;
        repeat (800) begin
            int dv;
            if ($urandom_range(0, 79) == 0) begin
                rst();
            end else begin
                if ($urandom_range(0, 9) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
                dv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 7));
                cyc(en, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                    dv, 1'($urandom_range(0, 1)));
            end
        end
        @(posedge clk_in);
        #3;
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
